fcb_spim_ctl: RTL and testbench
===============================

FCB_SPIM_CTL -- requirements
Module: fcb_spim_ctl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning SCK half-period in fcb_sys_clk cycles (legal 1..255).
REQ-002 SHALL have parameter CS_GAP, default 2, meaning minimum cycles with fcb_spim_cs_n high between frames (legal 1..255).
REQ-003 SHALL have port fcb_sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port fcb_sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fmic_spi_master_en  input  1  1 = master enabled; 0 = idle or abort.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1, req_wr input 1 (1 = write, 0 = read), req_addr input 7, req_wdata input 8: request handshake.
REQ-007 SHALL have ports rsp_valid output 1 (one-cycle pulse) and rsp_rdata output 8: read response.
REQ-008 SHALL have ports fcb_spim_sck output 1, fcb_spim_mosi output 1, fcb_spim_cs_n output 1, fcb_spim_miso input 1: SPI pins.
REQ-009 SHALL have port fcb_spim_busy output 1, high whenever state is not IDLE.

Function
REQ-010 SHALL drive 16-bit frames, MSB first, SPI mode 0: bit15 = req_wr, bits14:8 = req_addr, bits7:0 = req_wdata (read frames: bits7:0 driven 0).
REQ-011 SHALL assert req_ready only in IDLE with fmic_spi_master_en = 1; a transfer is accepted on a cycle with req_valid & req_ready.
REQ-012 SHALL capture the frame into a 16-bit shift register on accept; later changes to req_* SHALL have no effect.
REQ-013 SHALL implement states IDLE, SETUP, SCK_HI, SCK_LO, GAP.
REQ-014 IDLE -> SETUP on accept; cs_n low and mosi = bit15 from the next cycle.
REQ-015 SETUP SHALL last CLK_DIV cycles with sck low, then -> SCK_HI.
REQ-016 SCK_HI SHALL last CLK_DIV cycles with sck high; fcb_spim_miso SHALL be sampled on the first SCK_HI cycle of each bit.
REQ-017 SCK_LO SHALL last CLK_DIV cycles with sck low; mosi SHALL shift to the next bit on entry to SCK_LO.
REQ-018 A 5-bit bit counter SHALL count completed bits; after the 16th SCK_LO -> GAP with cs_n high and mosi 0.
REQ-019 cs_n low duration SHALL be exactly CLK_DIV*33 cycles per complete frame (66 at defaults).
REQ-020 GAP SHALL last CS_GAP cycles, then -> IDLE.
REQ-021 For read frames, rsp_rdata SHALL hold the MISO bits sampled during bits 7..0 (MSB first), and rsp_valid SHALL pulse for one cycle on the first GAP cycle; write frames SHALL produce no rsp_valid.
REQ-022 rsp_rdata SHALL hold its value until the next read response.
REQ-023 fmic_spi_master_en falling in SETUP/SCK_HI/SCK_LO SHALL abort: next cycle cs_n = 1, sck = 0, mosi = 0, state GAP, no rsp_valid.
REQ-024 fmic_spi_master_en = 0 in IDLE SHALL hold req_ready low; req_valid SHALL be ignored.
REQ-025 req_valid asserted during GAP SHALL wait; acceptance SHALL occur no earlier than the first IDLE cycle.

Reset
REQ-026 While fcb_sys_rst = 1: state IDLE, sck 0, cs_n 1, mosi 0, req_ready 0, rsp_valid 0, rsp_rdata 8'h00, busy 0, counters 0.
REQ-027 Reset asserted mid-frame SHALL force all outputs to reset values immediately (asynchronously), with no rsp_valid.
REQ-028 After reset release, req_ready SHALL follow REQ-011 from the first clock edge.

Verification
REQ-029 Write addr 7'h10 data 8'hA5, defaults -> MOSI sampled on sck rising = 1,0010000,10100101; cs_n low 66 cycles; no rsp_valid.
REQ-030 Read addr 7'h20, slave model returns 8'h3C on bits 7..0 -> rsp_valid one pulse, rsp_rdata = 8'h3C; MOSI bits7:0 = 0.
REQ-031 Back-to-back requests with req_valid held high -> cs_n high at least CS_GAP = 2 cycles between frames; second frame correct.
REQ-032 CLK_DIV = 1 -> sck toggles every cycle; cs_n low 33 cycles; data identical to REQ-029.
REQ-033 Drop fmic_spi_master_en after bit 5 of a read -> cs_n high next cycle, no rsp_valid, req_ready low until en returns and GAP ends.
REQ-034 Assert fcb_sys_rst mid-frame -> cs_n 1, sck 0, busy 0 with no clock edge; the next request after release completes normally.

Source files
------------

// File: rtl/fcb_spim_ctl.sv
`timescale 1ns/1ps
// SPI master (mode 0) issuing 16-bit register frames {wr, addr[6:0], data[7:0]}, MSB first.
// Pin outputs decode from registered state so an asynchronous reset clears them without a clock edge.
module fcb_spim_ctl #(
   parameter int CLK_DIV = 2,
   parameter int CS_GAP  = 2
) (
   input  logic       fcb_sys_clk,
   input  logic       fcb_sys_rst,
   input  logic       fmic_spi_master_en,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_wr,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       fcb_spim_sck,
   output logic       fcb_spim_mosi,
   output logic       fcb_spim_cs_n,
   input  logic       fcb_spim_miso,
   output logic       fcb_spim_busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SCK_HI,
      ST_SCK_LO,
      ST_GAP
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_div_cnt;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_shift;
   logic [7:0]  r_rx;
   logic        r_is_rd;
   logic [7:0]  r_rdata;
   logic        r_rsp_vld;
   logic        w_accept;
   logic        w_active;
   logic        w_abort;
   logic        w_div_done;
   logic        w_rsp_set;

   assign w_active   = (r_state == ST_SETUP) || (r_state == ST_SCK_HI) || (r_state == ST_SCK_LO);
   assign w_abort    = w_active & ~fmic_spi_master_en;
   assign w_div_done = (r_div_cnt == DIV_LAST);
   assign w_accept   = req_valid & req_ready;

   always_comb begin
      w_next    = r_state;
      w_rsp_set = 1'b0;
      case (r_state)
         ST_IDLE:   if (w_accept) w_next = ST_SETUP;
         ST_SETUP: begin
            if (w_abort)         w_next = ST_GAP;
            else if (w_div_done) w_next = ST_SCK_HI;
         end
         ST_SCK_HI: begin
            if (w_abort)         w_next = ST_GAP;
            else if (w_div_done) w_next = ST_SCK_LO;
         end
         ST_SCK_LO: begin
            // An abort on the final low phase still suppresses the response.
            if (w_abort) begin
               w_next = ST_GAP;
            end else if (w_div_done) begin
               if (r_bit_cnt == 5'd16) begin
                  w_next    = ST_GAP;
                  w_rsp_set = r_is_rd;
               end else begin
                  w_next = ST_SCK_HI;
               end
            end
         end
         ST_GAP:    if (r_div_cnt == GAP_LAST) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge fcb_sys_clk or posedge fcb_sys_rst) begin
      if (fcb_sys_rst) r_state <= ST_IDLE;
      else             r_state <= w_next;
   end

   always_ff @(posedge fcb_sys_clk or posedge fcb_sys_rst) begin
      if (fcb_sys_rst) begin
         r_div_cnt <= 8'd0;
         r_bit_cnt <= 5'd0;
         r_shift   <= 16'd0;
         r_rx      <= 8'd0;
         r_is_rd   <= 1'b0;
         r_rdata   <= 8'd0;
         r_rsp_vld <= 1'b0;
      end else begin
         r_rsp_vld <= w_rsp_set;
         if (w_rsp_set) r_rdata <= r_rx;

         if ((w_next != r_state) || (r_state == ST_IDLE)) r_div_cnt <= 8'd0;
         else                                             r_div_cnt <= r_div_cnt + 8'd1;

         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_shift   <= {req_wr, req_addr, (req_wr ? req_wdata : 8'h00)};
                  r_is_rd   <= ~req_wr;
                  r_bit_cnt <= 5'd0;
               end
            end
            ST_SCK_HI: begin
               // The last eight samples of a frame are the read data.
               if (r_div_cnt == 8'd0) r_rx <= {r_rx[6:0], fcb_spim_miso};
               if (w_next == ST_SCK_LO) begin
                  r_shift   <= {r_shift[14:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready     = (r_state == ST_IDLE) & fmic_spi_master_en & ~fcb_sys_rst;
   assign fcb_spim_sck  = (r_state == ST_SCK_HI);
   assign fcb_spim_cs_n = ~w_active;
   assign fcb_spim_mosi = w_active & r_shift[15];
   assign fcb_spim_busy = (r_state != ST_IDLE);
   assign rsp_valid     = r_rsp_vld;
   assign rsp_rdata     = r_rdata;

endmodule

// File: tb/tb_fcb_spim_ctl.sv
`timescale 1ns/1ps
// Directed bench: SPI slave model and pin monitor feeding per-scenario checks.
module tb_fcb_spim_ctl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_wr = 1'b0;
   logic [6:0] req_addr = 7'd0;
   logic [7:0] req_wdata = 8'd0;
   logic       miso = 1'b0;
   logic       sel = 1'b0;

   logic       rdy0, rv0, sck0, mosi0, csn0, busy0;
   logic [7:0] rd0;
   logic       rdy1, rv1, sck1, mosi1, csn1, busy1;
   logic [7:0] rd1;

   logic       m_rdy, m_rv, m_sck, m_mosi, m_csn, m_busy;
   logic [7:0] m_rd;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fcb_spim_ctl u_dut (
      .fcb_sys_clk(clk), .fcb_sys_rst(rst), .fmic_spi_master_en(en),
      .req_valid(req_valid & ~sel), .req_ready(rdy0), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv0), .rsp_rdata(rd0),
      .fcb_spim_sck(sck0), .fcb_spim_mosi(mosi0), .fcb_spim_cs_n(csn0),
      .fcb_spim_miso(miso), .fcb_spim_busy(busy0)
   );

   fcb_spim_ctl #(.CLK_DIV(1), .CS_GAP(2)) u_dut1 (
      .fcb_sys_clk(clk), .fcb_sys_rst(rst), .fmic_spi_master_en(en),
      .req_valid(req_valid & sel), .req_ready(rdy1), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv1), .rsp_rdata(rd1),
      .fcb_spim_sck(sck1), .fcb_spim_mosi(mosi1), .fcb_spim_cs_n(csn1),
      .fcb_spim_miso(miso), .fcb_spim_busy(busy1)
   );

   assign m_rdy  = sel ? rdy1  : rdy0;
   assign m_rv   = sel ? rv1   : rv0;
   assign m_sck  = sel ? sck1  : sck0;
   assign m_mosi = sel ? mosi1 : mosi0;
   assign m_csn  = sel ? csn1  : csn0;
   assign m_busy = sel ? busy1 : busy0;
   assign m_rd   = sel ? rd1   : rd0;

   // Slave model: presents s_tx MSB first, advancing after each falling SCK.
   logic [15:0] s_tx = 16'd0;
   logic [15:0] s_mosi = 16'd0;
   logic [15:0] last_word = 16'd0;
   logic [15:0] words [4];
   logic        prev_cs = 1'b1;
   logic        prev_sck = 1'b0;
   int s_cnt = 0, run_low = 0, run_hi = 0, run_gap = 0;
   int last_low = 0, last_hi = 0, last_gap = 0, frames = 0, rsp_pulses = 0;

   always @(negedge clk) begin
      if (m_csn) begin
         if (!prev_cs) begin
            last_low = run_low;
            last_hi = run_hi;
            last_word = s_mosi;
            words[frames & 3] = s_mosi;
            frames++;
            run_gap = 0;
         end
         run_gap++;
         s_cnt = 0;
      end else begin
         if (prev_cs) begin
            last_gap = run_gap;
            run_low = 0;
            run_hi = 0;
            s_mosi = 16'd0;
            s_cnt = 0;
         end
         run_low++;
         if (m_sck) run_hi++;
         if (prev_sck && !m_sck) s_cnt++;
         if (!prev_sck && m_sck) s_mosi = {s_mosi[14:0], m_mosi};
      end
      if (m_rv) rsp_pulses++;
      miso = (s_cnt < 16) ? s_tx[4'(15 - s_cnt)] : 1'b0;
      prev_cs = m_csn;
      prev_sck = m_sck;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_accept(output bit acc);
      acc = 1'b0;
      for (int i = 0; i < 300 && !acc; i++) begin
         if (m_rdy) acc = 1'b1;
         tick();
      end
   endtask

   task automatic run_frame(input logic wr, input logic [6:0] addr, input logic [7:0] wd,
                            input logic [15:0] stx, output bit ok);
      bit acc;
      int f0;
      s_tx = stx;
      req_wr = wr;
      req_addr = addr;
      req_wdata = wd;
      req_valid = 1'b1;
      f0 = frames;
      wait_accept(acc);
      req_valid = 1'b0;
      req_wr = ~wr;
      req_addr = ~addr;
      req_wdata = ~wd;
      for (int i = 0; i < 1000 && frames == f0; i++) tick();
      repeat (4) tick();
      ok = acc && (frames > f0);
   endtask

   task automatic test_reset();
      #3;
      if (sck0 !== 1'b0) begin $display("FAIL rst_sck: got %b want 0", sck0); n_bad++; end n_cmp++;
      if (csn0 !== 1'b1) begin $display("FAIL rst_cs_n: got %b want 1", csn0); n_bad++; end n_cmp++;
      if (mosi0 !== 1'b0) begin $display("FAIL rst_mosi: got %b want 0", mosi0); n_bad++; end n_cmp++;
      if (rdy0 !== 1'b0) begin $display("FAIL rst_ready: got %b want 0", rdy0); n_bad++; end n_cmp++;
      if (rv0 !== 1'b0) begin $display("FAIL rst_rsp_valid: got %b want 0", rv0); n_bad++; end n_cmp++;
      if (rd0 !== 8'h00) begin $display("FAIL rst_rdata: got %h want 00", rd0); n_bad++; end n_cmp++;
      if (busy0 !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy0); n_bad++; end n_cmp++;
      tick();
      tick();
      rst = 1'b0;
      tick();
      if (rdy0 !== 1'b1) begin $display("FAIL rel_ready: got %b want 1", rdy0); n_bad++; end n_cmp++;
   endtask

   task automatic test_write();
      bit ok;
      int r0 = rsp_pulses;
      run_frame(1'b1, 7'h10, 8'hA5, 16'h0000, ok);
      if (ok !== 1'b1) begin $display("FAIL wr_done: got %b want 1", ok); n_bad++; end n_cmp++;
      if (last_word !== 16'h90A5) begin $display("FAIL wr_mosi: got %h want 90a5", last_word); n_bad++; end n_cmp++;
      if (last_low != 66) begin $display("FAIL wr_cs_low: got %0d want 66", last_low); n_bad++; end n_cmp++;
      if (last_hi != 32) begin $display("FAIL wr_sck_hi: got %0d want 32", last_hi); n_bad++; end n_cmp++;
      if (rsp_pulses != r0) begin $display("FAIL wr_no_rsp: got %0d want %0d", rsp_pulses, r0); n_bad++; end n_cmp++;
      if (busy0 !== 1'b0) begin $display("FAIL wr_idle_busy: got %b want 0", busy0); n_bad++; end n_cmp++;
   endtask

   task automatic test_read();
      bit ok;
      int r0 = rsp_pulses;
      run_frame(1'b0, 7'h20, 8'hFF, 16'hA53C, ok);
      if (ok !== 1'b1) begin $display("FAIL rd_done: got %b want 1", ok); n_bad++; end n_cmp++;
      if (last_word !== 16'h2000) begin $display("FAIL rd_mosi: got %h want 2000", last_word); n_bad++; end n_cmp++;
      if (rsp_pulses != r0 + 1) begin $display("FAIL rd_rsp_pulse: got %0d want %0d", rsp_pulses - r0, 1); n_bad++; end n_cmp++;
      if (rd0 !== 8'h3C) begin $display("FAIL rd_rdata: got %h want 3c", rd0); n_bad++; end n_cmp++;
      if (last_low != 66) begin $display("FAIL rd_cs_low: got %0d want 66", last_low); n_bad++; end n_cmp++;
   endtask

   task automatic test_back_to_back();
      bit acc1, acc2;
      int f0 = frames;
      int r0 = rsp_pulses;
      req_wr = 1'b1;
      req_addr = 7'h11;
      req_wdata = 8'h5A;
      req_valid = 1'b1;
      wait_accept(acc1);
      req_addr = 7'h22;
      req_wdata = 8'hC3;
      wait_accept(acc2);
      req_valid = 1'b0;
      for (int i = 0; i < 1000 && frames < f0 + 2; i++) tick();
      repeat (4) tick();
      if ((acc1 && acc2) !== 1'b1) begin $display("FAIL b2b_accept: got %b%b want 11", acc1, acc2); n_bad++; end n_cmp++;
      if (words[f0 & 3] !== 16'h915A) begin $display("FAIL b2b_frame1: got %h want 915a", words[f0 & 3]); n_bad++; end n_cmp++;
      if (words[(f0 + 1) & 3] !== 16'hA2C3) begin $display("FAIL b2b_frame2: got %h want a2c3", words[(f0 + 1) & 3]); n_bad++; end n_cmp++;
      if (last_gap < 2) begin $display("FAIL b2b_gap: got %0d want >=2", last_gap); n_bad++; end n_cmp++;
      if (rd0 !== 8'h3C) begin $display("FAIL b2b_rdata_hold: got %h want 3c", rd0); n_bad++; end n_cmp++;
      if (rsp_pulses != r0) begin $display("FAIL b2b_no_rsp: got %0d want %0d", rsp_pulses, r0); n_bad++; end n_cmp++;
   endtask

   task automatic test_abort();
      bit acc;
      int r0 = rsp_pulses;
      s_tx = 16'hFFFF;
      req_wr = 1'b0;
      req_addr = 7'h05;
      req_valid = 1'b1;
      wait_accept(acc);
      req_valid = 1'b0;
      for (int i = 0; i < 200 && s_cnt < 6; i++) tick();
      en = 1'b0;
      tick();
      if (csn0 !== 1'b1) begin $display("FAIL abort_cs_n: got %b want 1", csn0); n_bad++; end n_cmp++;
      if (sck0 !== 1'b0) begin $display("FAIL abort_sck: got %b want 0", sck0); n_bad++; end n_cmp++;
      if (mosi0 !== 1'b0) begin $display("FAIL abort_mosi: got %b want 0", mosi0); n_bad++; end n_cmp++;
      if (busy0 !== 1'b1) begin $display("FAIL abort_gap_busy: got %b want 1", busy0); n_bad++; end n_cmp++;
      req_valid = 1'b1;
      repeat (6) tick();
      if (rdy0 !== 1'b0) begin $display("FAIL dis_ready: got %b want 0", rdy0); n_bad++; end n_cmp++;
      if (busy0 !== 1'b0) begin $display("FAIL dis_ignored: got %b want 0", busy0); n_bad++; end n_cmp++;
      en = 1'b1;
      #1;
      if (rdy0 !== 1'b1) begin $display("FAIL en_ready: got %b want 1", rdy0); n_bad++; end n_cmp++;
      req_valid = 1'b0;
      repeat (4) tick();
      if (rsp_pulses != r0) begin $display("FAIL abort_no_rsp: got %0d want %0d", rsp_pulses, r0); n_bad++; end n_cmp++;
   endtask

   task automatic test_reset_mid();
      bit acc, ok;
      int r0;
      s_tx = 16'h0000;
      req_wr = 1'b1;
      req_addr = 7'h33;
      req_wdata = 8'h0F;
      req_valid = 1'b1;
      wait_accept(acc);
      req_valid = 1'b0;
      for (int i = 0; i < 200 && s_cnt < 3; i++) tick();
      if (csn0 !== 1'b0) begin $display("FAIL mid_pre_cs_n: got %b want 0", csn0); n_bad++; end n_cmp++;
      #1 rst = 1'b1;
      #1;
      if (csn0 !== 1'b1) begin $display("FAIL mid_rst_cs_n: got %b want 1", csn0); n_bad++; end n_cmp++;
      if (sck0 !== 1'b0) begin $display("FAIL mid_rst_sck: got %b want 0", sck0); n_bad++; end n_cmp++;
      if (busy0 !== 1'b0) begin $display("FAIL mid_rst_busy: got %b want 0", busy0); n_bad++; end n_cmp++;
      if (rv0 !== 1'b0) begin $display("FAIL mid_rst_rsp: got %b want 0", rv0); n_bad++; end n_cmp++;
      tick();
      rst = 1'b0;
      tick();
      r0 = rsp_pulses;
      run_frame(1'b0, 7'h20, 8'h00, 16'h005A, ok);
      if (last_word !== 16'h2000) begin $display("FAIL mid_next_mosi: got %h want 2000", last_word); n_bad++; end n_cmp++;
      if (rd0 !== 8'h5A) begin $display("FAIL mid_next_rdata: got %h want 5a", rd0); n_bad++; end n_cmp++;
      if (rsp_pulses != r0 + 1) begin $display("FAIL mid_next_rsp: got %0d want 1", rsp_pulses - r0); n_bad++; end n_cmp++;
   endtask

   task automatic test_clkdiv1();
      bit ok;
      int r0;
      sel = 1'b1;
      repeat (3) tick();
      r0 = rsp_pulses;
      run_frame(1'b1, 7'h10, 8'hA5, 16'h0000, ok);
      if (ok !== 1'b1) begin $display("FAIL div1_done: got %b want 1", ok); n_bad++; end n_cmp++;
      if (last_word !== 16'h90A5) begin $display("FAIL div1_mosi: got %h want 90a5", last_word); n_bad++; end n_cmp++;
      if (last_low != 33) begin $display("FAIL div1_cs_low: got %0d want 33", last_low); n_bad++; end n_cmp++;
      if (last_hi != 16) begin $display("FAIL div1_sck_hi: got %0d want 16", last_hi); n_bad++; end n_cmp++;
      if (rsp_pulses != r0) begin $display("FAIL div1_no_rsp: got %0d want %0d", rsp_pulses, r0); n_bad++; end n_cmp++;
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_clkdiv1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
